// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback-arbiter definitions: FSM encoding, starvation defaults,
// and the register-hazard helper.
package wb_port_arbiter_pkg;

    localparam int CNT_W = 8;
    localparam int STARVE_LIMIT_DEF = 4;

    localparam logic [0:0] PIPE_PRI  = 1'b0;
    localparam logic [0:0] MDU_FORCE = 1'b1;

    typedef logic [4:0] reg_addr_t;

    // Same non-zero destination means the MDU result must land first.
    function automatic logic same_rd(input reg_addr_t a, input reg_addr_t b);
        return (a == b) && (a != '0);
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: two requesters in, one register-file write and
// scoreboard release out.
interface wb_port_arbiter_if #(parameter int DATA_W = 32);

    logic              pipe_valid;
    logic [4:0]        pipe_rd;
    logic [DATA_W-1:0] pipe_data;
    logic              pipe_ready;

    logic              mdu_valid;
    logic [4:0]        mdu_rd;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              release_valid;
    logic [4:0]        release_rd;
    logic              stall_M;

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data,
        input  mdu_valid, mdu_rd, mdu_data,
        output pipe_ready, mdu_ready,
        output rf_we, rf_waddr, rf_wdata,
        output release_valid, release_rd, stall_M
    );

    modport master (
        output pipe_valid, pipe_rd, pipe_data,
        output mdu_valid, mdu_rd, mdu_data,
        input  pipe_ready, mdu_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  release_valid, release_rd, stall_M
    );

endinterface

// File: rtl/wb_starve_cnt.sv
// Saturating count of consecutive cycles the MDU is denied writeback.
module wb_starve_cnt
    import wb_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset_E,
    input  logic             inc,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit,
    output logic             hit,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lim_m1;
    logic             at_limit_q;

    assign lim_m1 = (limit == '0) ? '0 : limit - CNT_W'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q < lim_m1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // This denial is the one that brings the count to its ceiling.
    assign hit = inc && !clr && (cnt_d == lim_m1);

    always_ff @(posedge clk or posedge reset_E) begin
        if (reset_E) begin
            cnt_q      <= '0;
            at_limit_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            at_limit_q <= hit;
        end
    end

    assign at_limit = at_limit_q;
    assign cnt      = cnt_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Two-requester writeback arbiter: pipe has priority, the MDU wins on a
// same-rd hazard or once it has starved too long.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          reset_E,
    wb_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [0:0]        state_q, state_d;
    logic              pipe_gnt, mdu_gnt;
    logic              inc, clr, hit, at_limit;
    logic [CNT_W-1:0]  wait_cnt;
    logic              win_vld;
    logic [4:0]        win_rd;
    logic [DATA_W-1:0] win_data;
    logic              rf_we_q;
    logic [4:0]        rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;

    always_comb begin
        pipe_gnt = 1'b0;
        mdu_gnt  = 1'b0;
        if (!reset_E) begin
            unique case (1'b1)
                (state_q == PIPE_PRI): begin
                    mdu_gnt = bus.mdu_valid &&
                              (!bus.pipe_valid ||
                               same_rd(bus.pipe_rd, bus.mdu_rd));
                    pipe_gnt = bus.pipe_valid && !mdu_gnt;
                end
                (state_q == MDU_FORCE): begin
                    mdu_gnt = bus.mdu_valid;
                end
            endcase
        end
    end

    assign inc = bus.mdu_valid && !mdu_gnt;
    assign clr = !bus.mdu_valid || mdu_gnt;

    wb_starve_cnt u_cnt (
        .clk      (clk),
        .reset_E  (reset_E),
        .inc      (inc),
        .clr      (clr),
        .limit    (LIMIT),
        .at_limit (at_limit),
        .hit      (hit),
        .cnt      (wait_cnt)
    );

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == PIPE_PRI): begin
                if (hit || (at_limit && inc))
                    state_d = MDU_FORCE;
            end
            (state_q == MDU_FORCE): begin
                if (mdu_gnt || !bus.mdu_valid)
                    state_d = PIPE_PRI;
            end
        endcase
    end

    assign win_vld  = pipe_gnt || mdu_gnt;
    assign win_rd   = mdu_gnt ? bus.mdu_rd : bus.pipe_rd;
    assign win_data = mdu_gnt ? bus.mdu_data : bus.pipe_data;

    always_ff @(posedge clk or posedge reset_E) begin
        if (reset_E) begin
            state_q    <= PIPE_PRI;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rf_we_q <= win_vld && (win_rd != '0);
            // x0 writes are dropped, so the last real write stays visible.
            if (win_vld && (win_rd != '0)) begin
                rf_waddr_q <= win_rd;
                rf_wdata_q <= win_data;
            end
        end
    end

    assign bus.pipe_ready    = pipe_gnt;
    assign bus.mdu_ready     = mdu_gnt;
    assign bus.stall_M       = bus.pipe_valid && !pipe_gnt;
    assign bus.rf_we         = rf_we_q;
    assign bus.rf_waddr      = rf_waddr_q;
    assign bus.rf_wdata      = rf_wdata_q;
    assign bus.release_valid = rf_we_q;
    assign bus.release_rd    = rf_waddr_q;

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register write-data width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive cycles the MDU may wait while the pipe wins.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port reset_E  in  1  reset; asynchronous, active-high (reset reset_E, asynchronous, active-high; clock clk).
REQ-005 SHALL have port pipe_valid  in  1  M-stage result pending writeback.
REQ-006 SHALL have ports pipe_rd  in  5  and pipe_data  in  DATA_W, the pipe destination and value.
REQ-007 SHALL have port pipe_ready  out  1  pipe result accepted this cycle.
REQ-008 SHALL have port mdu_valid  in  1  multi-cycle mul/div result pending.
REQ-009 SHALL have ports mdu_rd  in  5  and mdu_data  in  DATA_W, the MDU destination and value.
REQ-010 SHALL have port mdu_ready  out  1  MDU result accepted this cycle.
REQ-011 SHALL have ports rf_we  out  1,  rf_waddr  out  5  and  rf_wdata  out  DATA_W: the registered register-file write port.
REQ-012 SHALL have ports release_valid  out  1  and  release_rd  out  5: the scoreboard reservation clear.
REQ-013 SHALL have port stall_M  out  1  asserted when pipe_valid=1 and pipe_ready=0.

Function
REQ-014 A handshake SHALL complete on a requester when valid=1 and ready=1 at a rising clk edge; at most one handshake SHALL occur per cycle.
REQ-015 ready SHALL be combinational from the valid inputs, the current state and the rd values; it SHALL never depend on rf_* outputs.
REQ-016 The FSM SHALL have two states: PIPE_PRI (reset state) and MDU_FORCE.
REQ-017 In PIPE_PRI: pipe_valid=1 grants the pipe; otherwise mdu_valid=1 grants the MDU.
REQ-018 In PIPE_PRI, when both are valid and pipe_rd==mdu_rd with rd!=0, the MDU SHALL be granted, because the MDU is the older producer.
REQ-019 wait_cnt SHALL increment when mdu_valid=1 and the MDU is not granted; it SHALL clear on an MDU grant or when mdu_valid=0.
REQ-020 When wait_cnt reaches STARVE_LIMIT-1 while the MDU is still denied, the FSM SHALL go PIPE_PRI->MDU_FORCE.
REQ-021 In MDU_FORCE: the MDU SHALL be granted and pipe_ready=0. The FSM SHALL return to PIPE_PRI after the MDU handshake, or if mdu_valid drops.
REQ-022 Write latency SHALL be 1 cycle: the winner's rd and data appear on rf_waddr and rf_wdata on the edge after the handshake, with rf_we=1 for exactly one cycle.
REQ-023 A winner with rd==0 SHALL complete the handshake, but rf_we and release_valid SHALL stay 0.
REQ-024 release_valid and release_rd SHALL equal rf_we and rf_waddr in the same cycle.
REQ-025 With no handshake, rf_we=0 and release_valid=0; rf_waddr and rf_wdata SHALL hold their last values.
REQ-026 wait_cnt SHALL saturate at STARVE_LIMIT-1 and never wrap.

Reset
REQ-027 Asserting reset_E SHALL immediately force: state=PIPE_PRI, wait_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, release_valid=0, release_rd=0.
REQ-028 While reset_E=1, pipe_ready and mdu_ready SHALL be 0 and stall_M SHALL equal pipe_valid.
REQ-029 A handshake pending at a reset mid-operation SHALL be discarded; no write SHALL appear after reset deasserts.

Structure
REQ-030 The state encoding (PIPE_PRI=0, MDU_FORCE=1) and the default STARVE_LIMIT SHALL live in the shared pipeline package.
REQ-031 The starvation counter SHALL be a sub-module, wb_starve_cnt, with inputs inc, clr and limit and a registered output at_limit.

Verification
REQ-032 pipe_valid=1 with rd=5 and data=0xAAAA5555, mdu_valid=0 -> pipe_ready=1; the next cycle shows rf_we=1, rf_waddr=5, rf_wdata=0xAAAA5555, release_rd=5.
REQ-033 Both valid continuously for 4 cycles (pipe_rd=3, mdu_rd=7, STARVE_LIMIT=4) -> the pipe is granted on cycles 0-2, the FSM enters MDU_FORCE, and cycle 3 grants the MDU with stall_M=1.
REQ-034 Both valid with pipe_rd=mdu_rd=9 -> the MDU is granted first (rf_wdata=mdu_data), then the pipe on the next cycle.
REQ-035 mdu_valid=1 with mdu_rd=0 -> mdu_ready=1; rf_we=0 and release_valid=0 the next cycle.
REQ-036 reset_E pulsed on the cycle of a pipe handshake -> rf_we=0 throughout; state=PIPE_PRI and wait_cnt=0 after release.
REQ-037 In MDU_FORCE, mdu_valid drops before the grant -> return to PIPE_PRI the next cycle; a pending pipe_valid is then granted.
